drive_stream_bridge: RTL

- Clocked consumer placed directly downstream of the two-way drive/free merge stage.
- Detects the merged drive pulse and captures the concatenated word into a small FIFO.
- Presents captured words to synchronous logic as a valid/ready stream.
- Returns a free pulse upstream only when another word can be absorbed, so the upstream stage never needs to hold its data.

---
 rtl/fpga_control_pkg.sv | 18 +
 rtl/sync_fifo_d.sv | 72 +++++++
 rtl/drive_stream_bridge.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/fpga_control_pkg.sv
// Shared definitions for the drive/free stream bridge.
// Holds the bridge FSM encoding and a constant-evaluable clog2 helper
// used to size pointers, counters and the o_count port.
package fpga_control_pkg;

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] FREE       = 2'd1;
  localparam logic [1:0] WAIT_SPACE = 2'd2;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_d.sv
// Single-clock FIFO: storage, read/write pointers and occupancy count.
// Ports:
//   clk, rst    clock, synchronous active-high reset (clears storage too)
//   push, din   write din when push (accepted when not full, or when a
//               pop happens in the same cycle)
//   pop         advance head when pop and not empty
//   dout        head word, combinational from the registered read pointer
//   count       words held; empty / full flags
module sync_fifo_d
  import fpga_control_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push,
  input  logic [DATA_WIDTH-1:0]            din,
  input  logic                             pop,
  output logic [DATA_WIDTH-1:0]            dout,
  output logic [clog2(FIFO_DEPTH):0]       count,
  output logic                             empty,
  output logic                             full
);

  localparam int AW = clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]         wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]           cnt_q, cnt_d;
  logic                  do_push, do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign count = cnt_q;
  assign dout  = mem_q[rd_q];

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    if (do_push) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + 1'b1;  // power-of-two depth: natural wrap
    end
    if (do_pop) rd_d = rd_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/drive_stream_bridge.sv
// Consumer downstream of the drive/free merge stage.
// Synchronizes the asynchronous i_drive pulse, captures i_data into a FIFO
// on each detected rising edge and hands the word back as a valid/ready
// stream. A free pulse (FREE_PULSE cycles) is returned upstream only when
// another word can still be absorbed; with the FIFO full the free is held
// back until the first pop.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   i_drive, i_data     upstream drive pulse (async) and word
//   o_free              registered free pulse to upstream
//   o_valid, i_ready    stream handshake; o_data is the FIFO head
//   o_count             words held
//   o_overflow          sticky: drive edge seen while not in IDLE
module drive_stream_bridge
  import fpga_control_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int FREE_PULSE = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_drive,
  output logic                        o_free,
  input  logic [DATA_WIDTH-1:0]       i_data,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [DATA_WIDTH-1:0]       o_data,
  output logic [clog2(FIFO_DEPTH):0]  o_count,
  output logic                        o_overflow
);

  localparam int CW = clog2(FIFO_DEPTH) + 1;
  localparam int PW = clog2(FREE_PULSE + 1);

  logic          s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [1:0]    vld_pipe_q, vld_pipe_d;
  logic          arm_q, arm_d;
  logic          edge_q, edge_d;
  logic [1:0]    state_q, state_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic          free_q, free_d;
  logic          ovf_q, ovf_d;

  logic          fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [CW-1:0] fifo_count;

  assign o_valid    = ~fifo_empty;
  assign o_count    = fifo_count;
  assign o_free     = free_q;
  assign o_overflow = ovf_q;
  assign fifo_pop   = o_valid & i_ready;

  always_comb begin
    s1_d       = i_drive;
    s2_d       = s1_q;
    s3_d       = s2_q;
    // vld_pipe marks when s2 holds a genuine post-reset sample. Arming only
    // on such a low sample means a drive held high across reset release
    // never produces an edge.
    vld_pipe_d = {vld_pipe_q[0], 1'b1};
    arm_d      = arm_q | (vld_pipe_q[1] & ~s2_q);
    // Registered edge gives the three-edge drive-to-push latency.
    edge_d     = arm_q & s2_q & ~s3_q;

    state_d    = state_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    fifo_push  = 1'b0;

    case (state_q)
      IDLE: begin
        if (edge_q) begin
          // IDLE always has a free slot; the full term is only defensive.
          fifo_push = ~fifo_full | fifo_pop;
          // Room after this push iff a pop coincides or count < DEPTH-1.
          if (fifo_pop || (fifo_count < CW'(FIFO_DEPTH - 1))) begin
            state_d = FREE;
            cnt_d   = PW'(FREE_PULSE);
          end else begin
            state_d = WAIT_SPACE;
          end
        end
      end
      FREE: begin
        if (edge_q) ovf_d = 1'b1;
        if (cnt_q == PW'(1)) state_d = IDLE;
        else                 cnt_d   = cnt_q - 1'b1;
      end
      WAIT_SPACE: begin
        if (edge_q) ovf_d = 1'b1;
        if (fifo_pop) begin
          state_d = FREE;
          cnt_d   = PW'(FREE_PULSE);
        end
      end
      default: state_d = IDLE;
    endcase

    free_d = (state_d == FREE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      vld_pipe_q <= '0;
      arm_q      <= 1'b0;
      edge_q     <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      free_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
      vld_pipe_q <= vld_pipe_d;
      arm_q      <= arm_d;
      edge_q     <= edge_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      free_q     <= free_d;
      ovf_q      <= ovf_d;
    end
  end

  sync_fifo_d #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (i_data),
    .pop   (fifo_pop),
    .dout  (o_data),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

endmodule
